pkt_tx_framer: RTL and testbench
================================

Name: pkt_tx_framer

Overview:
- Transmit-side counterpart of the packet assembler: turns one response request (opcode + payload) into a framed byte stream and drives it into the uart_core TX byte interface.
- Sits between response sources (status reply, future readback commands) and uart_core.
- Frame on the wire: SYNC, LEN, OPCODE, PAYLOAD[0..N-1], CRC.
- One frame in flight at a time; the request side is stalled until the CRC byte has been accepted by the UART.

Parameters:
- MAX_PAYLOAD, 16, maximum payload bytes per frame (1..253).
- SYNC, 8'hAA, first byte of every frame; same value the receive side hunts for.
- CRC_INIT, 8'h00, CRC-8 seed at the start of each frame.

Ports:
- CLK  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  response request present.
- req_ready  out  1  framer idle and able to accept a request.
- req_opcode  in  8  OPCODE byte of the response.
- req_len  in  8  payload byte count N (0..MAX_PAYLOAD).
- req_payload  in  8*MAX_PAYLOAD  payload bytes; byte k is at [8k +: 8]; bytes at k >= N are ignored.
- tx_data  out  8  byte to uart_core.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  uart_core can take a byte.
- busy  out  1  frame in progress (state != IDLE); intended for the BUSY status vector.
- frame_done  out  1  one-cycle pulse in the cycle the CRC byte handshake completes.
- err_len  out  1  one-cycle pulse when a request with req_len > MAX_PAYLOAD is accepted and dropped.

Behaviour:
- Reset values: req_ready=1, tx_valid=0, tx_data=0, busy=0, frame_done=0, err_len=0, CRC=CRC_INIT, byte counter=0, state=IDLE.
- Request acceptance:
  - A request is accepted when req_valid && req_ready.
  - On acceptance, opcode, len and payload are latched into internal registers; inputs may change afterwards.
  - req_ready = (state == IDLE).
- Length error: if the latched req_len > MAX_PAYLOAD, pulse err_len on the next cycle, emit no bytes, and remain in IDLE.
- LEN byte value: LEN = 1 + N (counts OPCODE plus payload). N=0 is legal and produces a 4-byte frame.
- CRC:
  - CRC-8, polynomial x^8+x^2+x+1 (0x07), MSB-first, no reflection, no final XOR, seeded with CRC_INIT.
  - Covers LEN, OPCODE and payload bytes. SYNC and the CRC byte itself are excluded.
  - The running CRC is updated in the cycle each covered byte completes its handshake.
- State machine transitions:
  - IDLE -> SYNC on accept with a valid length.
  - SYNC -> LEN, LEN -> OP on each handshake.
  - OP -> PAY if N>0, else OP -> CRC.
  - PAY -> CRC after byte N-1.
  - CRC -> IDLE on handshake, pulsing frame_done.
- Output handshake:
  - tx_valid/tx_data are registered and driven in every non-IDLE state.
  - A byte is transferred on tx_valid && tx_ready. The next byte is presented in the following cycle, so maximum throughput is one byte per cycle when tx_ready is held high.
  - tx_data must not change while tx_valid=1 and tx_ready=0.
- Latency: first SYNC byte appears on tx_valid 1 cycle after acceptance. A back-to-back request may be accepted in the cycle after frame_done.
- tx_ready stalls of any length in any state must not corrupt the byte or the CRC.
- Reset mid-frame: the frame is abandoned immediately; tx_valid drops in the cycle after rst and no partial CRC is sent.
- Simultaneous events: req_valid while busy is ignored (not latched); the source must hold it. err_len and frame_done can never pulse in the same cycle.

Optional Feature:
- Macro: PKT_TX_SEQ_EN.
- When defined:
  - An 8-bit sequence byte is inserted between OPCODE and PAYLOAD.
  - LEN = 2 + N, and the CRC covers the SEQ byte.
  - The sequence counter resets to 0, increments by 1 on each frame_done, and wraps 255 -> 0. Dropped (err_len) requests do not increment it.
- When undefined: no SEQ state, no sequence counter, frame exactly as above.

Test Plan:
- Zero-payload frame: req_opcode=8'h07, req_len=0, tx_ready=1 -> bytes AA 01 07 00; frame_done pulses with the 4th handshake; req_ready returns high the next cycle.
- One-byte payload: opcode 8'h07, len 1, payload 8'h03, tx_ready=1 -> AA 02 07 03 B4, sent on consecutive cycles after the 1-cycle start latency.
- Backpressure: same as the previous scenario with tx_ready toggled by random 0-5 cycle stalls -> identical byte sequence, tx_data stable during every stall, one frame_done.
- Length error: req_len = MAX_PAYLOAD+1 -> single err_len pulse, tx_valid stays 0, req_ready stays 1; a following legal request frames correctly.
- Reset mid-frame: assert rst during the PAY state of a 16-byte frame -> tx_valid=0 next cycle; a new opcode-8'h07, len-0 request yields AA 01 07 00, confirming the CRC was re-seeded.
- With PKT_TX_SEQ_EN defined: send 257 zero-payload frames -> the SEQ byte runs 00..FF then 00; each frame's CRC matches the bench CRC-8 model.

Source files
------------

// File: rtl/pkt_tx_framer.sv
// Purpose : frames one response request as SYNC, LEN, OPCODE, [SEQ], PAYLOAD, CRC8 onto the uart_core TX byte port.
// Latency : SYNC is presented 1 cycle after acceptance; then 1 byte/cycle while tx_ready is high.
// Backpr. : tx_data/tx_valid are held while tx_ready=0; req_ready stays low until the CRC byte is taken.
//
// Ports:
//   CLK, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake; req_ready is high only in IDLE
//   req_opcode, req_len      OPCODE byte and payload count N (0..MAX_PAYLOAD)
//   req_payload              payload bytes, byte k at [8k +: 8]
//   tx_data/tx_valid/tx_ready  registered byte stream to uart_core
//   busy                     a frame is in progress
//   frame_done               pulse in the cycle the CRC byte is handed over
//   err_len                  pulse the cycle after an oversize request is dropped
//
// Optional build macro: PKT_TX_SEQ_EN inserts an 8-bit frame sequence byte after OPCODE.
module pkt_tx_framer #(
    parameter int          MAX_PAYLOAD = 16,
    parameter logic [7:0]  SYNC        = 8'hAA,
    parameter logic [7:0]  CRC_INIT    = 8'h00
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [7:0]               req_opcode,
    input  logic [7:0]               req_len,
    input  logic [8*MAX_PAYLOAD-1:0] req_payload,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     err_len
);

    localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);
`ifdef PKT_TX_SEQ_EN
    localparam logic [7:0] LEN_OVH = 8'd2;   // OPCODE + SEQ
`else
    localparam logic [7:0] LEN_OVH = 8'd1;   // OPCODE only
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_LEN,
        S_OP,
`ifdef PKT_TX_SEQ_EN
        S_SEQ,
`endif
        S_PAY,
        S_CRC
    } state_t;

    // One CRC-8 (poly 0x07, MSB first) step over a whole byte.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] dat);
        logic [7:0] c;
        c = crc ^ dat;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    state_t                   r_state,   w_state_nxt;
    logic [7:0]               r_opcode,  w_opcode_nxt;
    logic [7:0]               r_len,     w_len_nxt;
    logic [8*MAX_PAYLOAD-1:0] r_payload, w_payload_nxt;
    logic [7:0]               r_cnt,     w_cnt_nxt;
    logic [7:0]               r_crc,     w_crc_nxt;
    logic [7:0]               r_tx_data, w_tx_data_nxt;
    logic                     r_tx_valid, w_tx_valid_nxt;
    logic                     r_err_len, w_err_len_nxt;
    logic                     w_frame_done;
`ifdef PKT_TX_SEQ_EN
    logic [7:0]               r_seq,     w_seq_nxt;
`endif

    logic                     w_hs;
    logic [7:0]               w_crc_upd;
    logic [7:0]               w_cnt_inc;
    logic [7:0]               w_pay_next;

    // The byte on tx_data is folded into the CRC as it is handed over, so the
    // CRC byte can be presented the very next cycle from w_crc_upd.
    assign w_hs       = r_tx_valid && tx_ready;
    assign w_crc_upd  = crc8_byte(r_crc, r_tx_data);
    assign w_cnt_inc  = r_cnt + 8'd1;
    assign w_pay_next = r_payload[{w_cnt_inc, 3'b000} +: 8];

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_opcode   <= 8'h00;
            r_len      <= 8'h00;
            r_payload  <= '0;
            r_cnt      <= 8'h00;
            r_crc      <= CRC_INIT;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_err_len  <= 1'b0;
`ifdef PKT_TX_SEQ_EN
            r_seq      <= 8'h00;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_opcode   <= w_opcode_nxt;
            r_len      <= w_len_nxt;
            r_payload  <= w_payload_nxt;
            r_cnt      <= w_cnt_nxt;
            r_crc      <= w_crc_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_err_len  <= w_err_len_nxt;
`ifdef PKT_TX_SEQ_EN
            r_seq      <= w_seq_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_opcode_nxt   = r_opcode;
        w_len_nxt      = r_len;
        w_payload_nxt  = r_payload;
        w_cnt_nxt      = r_cnt;
        w_crc_nxt      = r_crc;
        w_tx_data_nxt  = r_tx_data;
        w_tx_valid_nxt = r_tx_valid;
        w_err_len_nxt  = 1'b0;
        w_frame_done   = 1'b0;
`ifdef PKT_TX_SEQ_EN
        w_seq_nxt      = r_seq;
`endif

        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_opcode_nxt  = req_opcode;
                    w_len_nxt     = req_len;
                    w_payload_nxt = req_payload;
                    if (req_len > MAX_LEN) begin
                        // Oversize request is consumed and dropped; stay idle.
                        w_err_len_nxt = 1'b1;
                    end else begin
                        w_state_nxt    = S_SYNC;
                        w_tx_data_nxt  = SYNC;
                        w_tx_valid_nxt = 1'b1;
                        w_crc_nxt      = CRC_INIT;
                        w_cnt_nxt      = 8'h00;
                    end
                end
            end

            S_SYNC: begin
                if (w_hs) begin
                    w_state_nxt   = S_LEN;
                    w_tx_data_nxt = r_len + LEN_OVH;
                end
            end

            S_LEN: begin
                if (w_hs) begin
                    w_crc_nxt     = w_crc_upd;
                    w_state_nxt   = S_OP;
                    w_tx_data_nxt = r_opcode;
                end
            end

            S_OP: begin
                if (w_hs) begin
                    w_crc_nxt = w_crc_upd;
`ifdef PKT_TX_SEQ_EN
                    w_state_nxt   = S_SEQ;
                    w_tx_data_nxt = r_seq;
`else
                    if (r_len != 8'h00) begin
                        w_state_nxt   = S_PAY;
                        w_tx_data_nxt = r_payload[7:0];
                        w_cnt_nxt     = 8'h00;
                    end else begin
                        w_state_nxt   = S_CRC;
                        w_tx_data_nxt = w_crc_upd;
                    end
`endif
                end
            end

`ifdef PKT_TX_SEQ_EN
            S_SEQ: begin
                if (w_hs) begin
                    w_crc_nxt = w_crc_upd;
                    if (r_len != 8'h00) begin
                        w_state_nxt   = S_PAY;
                        w_tx_data_nxt = r_payload[7:0];
                        w_cnt_nxt     = 8'h00;
                    end else begin
                        w_state_nxt   = S_CRC;
                        w_tx_data_nxt = w_crc_upd;
                    end
                end
            end
`endif

            S_PAY: begin
                if (w_hs) begin
                    w_crc_nxt = w_crc_upd;
                    if (r_cnt == r_len - 8'd1) begin
                        w_state_nxt   = S_CRC;
                        w_tx_data_nxt = w_crc_upd;
                    end else begin
                        w_cnt_nxt     = w_cnt_inc;
                        w_tx_data_nxt = w_pay_next;
                    end
                end
            end

            S_CRC: begin
                if (w_hs) begin
                    w_frame_done   = 1'b1;
                    w_state_nxt    = S_IDLE;
                    w_tx_valid_nxt = 1'b0;
                    w_tx_data_nxt  = 8'h00;
`ifdef PKT_TX_SEQ_EN
                    w_seq_nxt      = r_seq + 8'd1;
`endif
                end
            end

            default: begin
                w_state_nxt    = S_IDLE;
                w_tx_valid_nxt = 1'b0;
            end
        endcase
    end

    assign req_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign tx_data    = r_tx_data;
    assign tx_valid   = r_tx_valid;
    assign frame_done = w_frame_done;
    assign err_len    = r_err_len;

endmodule

// File: tb/tb_pkt_tx_framer.sv
// Purpose : self-checking bench for pkt_tx_framer against a frame-level reference model.
// Latency : checks SYNC one cycle after accept and back-to-back bytes with tx_ready held high.
// Backpr. : random tx_ready stalls; tx_data must hold during every stall.
module tb_pkt_tx_framer;

    localparam int MAXP = 16;
    typedef logic [7:0] byte_q_t[$];

    logic              CLK = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [7:0]        req_opcode;
    logic [7:0]        req_len;
    logic [8*MAXP-1:0] req_payload;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;
    logic              frame_done;
    logic              err_len;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] got[$];
    int         fd_cnt;
    bit         bp_en;
    int         exp_seq;

    always #5 CLK = ~CLK;

    pkt_tx_framer #(.MAX_PAYLOAD(MAXP)) dut (
        .CLK(CLK), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_len(req_len), .req_payload(req_payload),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .frame_done(frame_done), .err_len(err_len)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Serial LFSR form of CRC-8/0x07, one message bit at a time.
    function automatic logic [7:0] crc_serial(input logic [7:0] c, input logic [7:0] b);
        logic fb;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ b[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    function automatic byte_q_t model(input logic [7:0] op, input logic [7:0] len,
                                      input logic [8*MAXP-1:0] pl, input logic [7:0] seq);
        byte_q_t    q;
        logic [7:0] c;
        q.push_back(8'hAA);
`ifdef PKT_TX_SEQ_EN
        q.push_back(8'(len + 8'd2));
        q.push_back(op);
        q.push_back(seq);
`else
        q.push_back(8'(len + 8'd1));
        q.push_back(op);
        if (seq != seq) q.push_back(8'h00);
`endif
        for (int k = 0; k < int'(len); k++) q.push_back(pl[8*k +: 8]);
        c = 8'h00;
        for (int k = 1; k < q.size(); k++) c = crc_serial(c, q[k]);
        q.push_back(c);
        return q;
    endfunction

    // tx_ready driver: ready for one cycle, then a random 0-5 cycle stall.
    initial begin
        int stall_left;
        stall_left = 0;
        tx_ready   = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            if (bp_en) begin
                if (stall_left > 0) begin
                    tx_ready = 1'b0;
                    stall_left--;
                end else begin
                    tx_ready   = 1'b1;
                    stall_left = $urandom_range(0, 5);
                end
            end else begin
                tx_ready = 1'b1;
            end
        end
    end

    // Byte collector and per-cycle invariants, sampled mid-cycle.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        fd_cnt     = 0;
        forever begin
            @(negedge CLK);
            if (prev_stall) check("stall_stable", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, prev_data});
            if (frame_done || err_len) check("fd_err_excl", {31'd0, frame_done && err_len}, 32'd0);
            if (tx_valid && tx_ready && !rst) got.push_back(tx_data);
            if (frame_done && !rst) fd_cnt++;
            prev_stall = tx_valid && !tx_ready && !rst;
            prev_data  = tx_data;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] op, input logic [7:0] len,
                        input logic [8*MAXP-1:0] pl, input bit bp);
        byte_q_t expq;
        int      n;
        expq = model(op, len, pl, 8'(exp_seq));
        n = 0;
        while (!req_ready && n < 100) begin step(); n++; end
        check("req_ready_wait", {31'd0, req_ready}, 32'd1);
        bp_en = bp;
        got.delete();
        fd_cnt = 0;
        req_valid = 1'b1; req_opcode = op; req_len = len; req_payload = pl;
        step();
        // Scramble inputs after acceptance: the frame must come from latched copies.
        req_valid = 1'b0; req_opcode = 8'($urandom); req_len = 8'($urandom);
        req_payload = {$urandom, $urandom, $urandom, $urandom};
        @(negedge CLK);
        check("sync_latency", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hAA});
        n = 1;
        while (!frame_done && n < 3000) begin @(negedge CLK); n++; end
        check("frame_done_seen", {31'd0, frame_done}, 32'd1);
        if (!bp) check("throughput_cycles", n, expq.size());
        step();
        bp_en = 1'b0;
        check("frame_done_count", fd_cnt, 1);
        check("frame_len", got.size(), expq.size());
        for (int i = 0; i < expq.size(); i++)
            if (i < got.size()) check($sformatf("byte%0d", i), {24'd0, got[i]}, {24'd0, expq[i]});
        @(negedge CLK);
        check("ready_after_done", {30'd0, req_ready, busy}, {30'd0, 1'b1, 1'b0});
        exp_seq = (exp_seq + 1) % 256;
    endtask

    task automatic check_const(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3,
                               input logic [7:0] b4, input int nb);
        logic [7:0] ref_b[5];
        ref_b = '{b0, b1, b2, b3, b4};
        check({tag, "_size"}, got.size(), nb);
        for (int i = 0; i < nb; i++)
            if (i < got.size()) check($sformatf("%s_b%0d", tag, i), {24'd0, got[i]}, {24'd0, ref_b[i]});
    endtask

    initial begin
        int n;
        rst = 1'b1; req_valid = 1'b0; req_opcode = 8'h00; req_len = 8'h00;
        req_payload = '0; bp_en = 1'b0; exp_seq = 0;
        repeat (3) step();
        @(negedge CLK);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_flags", {30'd0, frame_done, err_len}, 32'd0);
        step();
        rst = 1'b0;
        step();

        // Zero payload frame and one-byte payload frame, fixed expectations.
        send(8'h07, 8'd0, '0, 1'b0);
`ifndef PKT_TX_SEQ_EN
        check_const("zero_pl", 8'hAA, 8'h01, 8'h07, 8'h00, 8'h00, 4);
`endif
        send(8'h07, 8'd1, {{(8*MAXP-8){1'b0}}, 8'h03}, 1'b0);
`ifndef PKT_TX_SEQ_EN
        check_const("one_pl", 8'hAA, 8'h02, 8'h07, 8'h03, 8'hB4, 5);
`endif
        send(8'h07, 8'd1, {{(8*MAXP-8){1'b0}}, 8'h03}, 1'b1);
`ifndef PKT_TX_SEQ_EN
        check_const("one_pl_bp", 8'hAA, 8'h02, 8'h07, 8'h03, 8'hB4, 5);
`endif

        // Oversize request: dropped with a single err_len pulse.
        got.delete();
        req_valid = 1'b1; req_opcode = 8'h55; req_len = 8'(MAXP + 1);
        step();
        req_valid = 1'b0;
        @(negedge CLK);
        check("err_len_pulse", {31'd0, err_len}, 32'd1);
        check("err_no_tx", {30'd0, tx_valid, req_ready}, {30'd0, 1'b0, 1'b1});
        step();
        @(negedge CLK);
        check("err_len_clear", {31'd0, err_len}, 32'd0);
        repeat (4) step();
        check("err_no_bytes", got.size(), 0);
        send(8'h3C, 8'd2, {{(8*MAXP-16){1'b0}}, 16'hBEEF}, 1'b0);

        // Randomized frames, including the maximum length, with random stalls.
        send(8'($urandom), 8'(MAXP), {$urandom, $urandom, $urandom, $urandom}, 1'b1);
        for (int i = 0; i < 10; i++)
            send(8'($urandom), 8'($urandom_range(0, MAXP)),
                 {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));

        // Reset during the payload of a full-length frame.
        got.delete();
        req_valid = 1'b1; req_opcode = 8'h11; req_len = 8'(MAXP);
        req_payload = {$urandom, $urandom, $urandom, $urandom};
        step();
        req_valid = 1'b0;
        n = 0;
        while (got.size() < 6 && n < 200) begin @(negedge CLK); n++; end
        check("mid_frame_progress", {31'd0, got.size() >= 6}, 32'd1);
        step();
        rst = 1'b1;
        step();
        @(negedge CLK);
        check("rst_mid_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_mid_idle", {30'd0, busy, req_ready}, {30'd0, 1'b0, 1'b1});
        step();
        rst = 1'b0;
        exp_seq = 0;
        step();
        send(8'h07, 8'd0, '0, 1'b0);
`ifndef PKT_TX_SEQ_EN
        check_const("after_rst", 8'hAA, 8'h01, 8'h07, 8'h00, 8'h00, 4);
`endif

`ifdef PKT_TX_SEQ_EN
        // Sequence counter: restart from 0 and run through a full wrap.
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_seq = 0;
        step();
        for (int i = 0; i < 257; i++) begin
            send(8'h07, 8'd0, '0, 1'b0);
            if (got.size() > 3) check($sformatf("seq_%0d", i), {24'd0, got[3]}, i % 256);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
